// File: rtl/apb_multi_slave_master_pkg.sv
// Shared types for the multi-slave APB3 master: the FSM state encoding and the
// helper that sizes the slave-index field.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DECERR = 2'd3
  } apb_state_e;

  // Width of the slave-index field; kept at 1 bit so a degenerate NUM_SLV still elaborates.
  function automatic int idx_width(input int num_slv);
    return (num_slv > 1) ? $clog2(num_slv) : 1;
  endfunction

endpackage

// File: rtl/apb_multi_slave_master_if.sv
// Bundle for the multi-slave APB master: requester handshake on one side and
// the APB3 bus towards NUM_SLV slaves on the other.
interface apb_multi_slave_master_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4
);

  // Requester side
  logic                      transfer;
  logic                      pwrite_in;
  logic [ADDR_W-1:0]         addr;
  logic [DATA_W-1:0]         wdata;
  logic                      req_ready;
  logic                      rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;

  // APB side
  logic [NUM_SLV-1:0]        psel;
  logic                      penable;
  logic                      pwrite;
  logic [ADDR_W-1:0]         paddr;
  logic [DATA_W-1:0]         pwdata;
  logic [NUM_SLV*DATA_W-1:0] prdata;
  logic [NUM_SLV-1:0]        pready;
  logic [NUM_SLV-1:0]        pslverr;

  modport master (
    input  transfer, pwrite_in, addr, wdata, prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pwdata
  );

  // The environment: requester plus the slaves.
  modport slave (
    output transfer, pwrite_in, addr, wdata, prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/apb_multi_slave_master_addr_decoder.sv
// Combinational slave decoder: the index comes from addr[SLV_ADDR_LSB +: IDX_W];
// any set bit above that field is a decode error and selects nothing.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int NUM_SLV      = 4,
  parameter int SLV_ADDR_LSB = 12
) (
  input  logic [ADDR_W-1:0]                addr,
  output logic [NUM_SLV-1:0]               sel,
  output logic [idx_width(NUM_SLV)-1:0]    idx,
  output logic                             dec_err
);

  localparam int IDX_W  = idx_width(NUM_SLV);
  localparam int HI_LSB = SLV_ADDR_LSB + IDX_W;

  logic upper_nz;

  if (HI_LSB < ADDR_W) begin : g_upper
    assign upper_nz = |addr[ADDR_W-1:HI_LSB];
  end else begin : g_no_upper
    assign upper_nz = 1'b0;
  end

  // Offset bits inside a slave window play no part in the decode.
  if (SLV_ADDR_LSB > 0) begin : g_offset
    logic [SLV_ADDR_LSB-1:0] offset_unused;
    assign offset_unused = addr[SLV_ADDR_LSB-1:0];
  end

  always_comb begin
    idx     = addr[SLV_ADDR_LSB +: IDX_W];
    dec_err = upper_nz;
    sel     = dec_err ? '0 : (NUM_SLV'(1) << idx);
  end

endmodule

// File: rtl/apb_multi_slave_master.sv
// APB3 master with integrated address decoder for NUM_SLV slaves.
// Optional build macro APB_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYC stalled cycles.
module apb_multi_slave_master
  import apb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int NUM_SLV      = 4,
  parameter int SLV_ADDR_LSB = 12,
  parameter int TIMEOUT_CYC  = 16
) (
  input  logic                      pclk,
  input  logic                      presetn,
  apb_multi_slave_master_if.master  bus
);

  localparam int IDX_W = idx_width(NUM_SLV);

  apb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic [NUM_SLV-1:0]  psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic [NUM_SLV-1:0]  dec_sel;
  logic [IDX_W-1:0]    dec_idx;
  logic                dec_err;

  logic                accept;
  logic                cur_ready;
  logic                cur_err;
  logic [DATA_W-1:0]   cur_rdata;
  logic                timeout_hit;

  apb_addr_decoder #(
    .ADDR_W       (ADDR_W),
    .NUM_SLV      (NUM_SLV),
    .SLV_ADDR_LSB (SLV_ADDR_LSB)
  ) u_dec (
    .addr    (bus.addr),
    .sel     (dec_sel),
    .idx     (dec_idx),
    .dec_err (dec_err)
  );

  // Only the latched slave's response lines matter; the rest are don't-care.
  assign accept    = bus.transfer && req_ready_q;
  assign cur_ready = bus.pready[idx_q];
  assign cur_err   = bus.pslverr[idx_q];
  assign cur_rdata = bus.prdata[idx_q*DATA_W +: DATA_W];

`ifdef APB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt_q;

  // Abort on the edge that would bring the stall count to TIMEOUT_CYC; pready in that cycle wins.
  assign timeout_hit = (state_q == ACCESS) && !cur_ready &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      to_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      to_cnt_q <= '0;
    end else if (state_q == ACCESS && !cur_ready) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  logic [31:0] timeout_unused;

  assign timeout_hit    = 1'b0;
  assign timeout_unused = 32'(TIMEOUT_CYC);
`endif

  // State and output registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state logic.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = dec_err ? DECERR : SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (cur_ready || timeout_hit) state_d = IDLE;
      DECERR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; everything holds unless changed.
  always_comb begin
    idx_d       = idx_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    req_ready_d = (state_d == IDLE);

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d     = dec_idx;
          psel_d    = dec_sel;
          penable_d = 1'b0;
          pwrite_d  = bus.pwrite_in;
          paddr_d   = bus.addr;
          pwdata_d  = bus.wdata;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (cur_ready) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = cur_err;
          rsp_rdata_d = (!pwrite_q && !cur_err) ? cur_rdata : '0;
        end else if (timeout_hit) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      DECERR: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_rdata_d = '0;
      end
      default: ;
    endcase
  end

  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_multi_slave_master.sv
// Scoreboard bench for apb_multi_slave_master (NUM_SLV=4, SLV_ADDR_LSB=12): directed
// transfers push expected responses; a monitor pops and compares on rsp_valid.
module tb_apb_multi_slave_master;

  logic pclk    = 1'b0;
  logic presetn = 1'b0;
  int   cyc     = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];

  apb_multi_slave_master_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4)) bus ();

  apb_multi_slave_master #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .NUM_SLV      (4),
    .SLV_ADDR_LSB (12),
    .TIMEOUT_CYC  (16)
  ) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response strobe must match the oldest expectation, including its cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge pclk);
      if (presetn && bus.rsp_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_rsp", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("rsp_rdata", bus.rsp_rdata, e.rdata);
          check("rsp_err",   bus.rsp_err,   e.err);
          check("rsp_cycle", cyc,           e.cyc);
        end
      end
    end
  end

  // Present a request, wait (bounded) for acceptance, log the expected response.
  // Returns just after the accepting edge; the next negedge is the SETUP (or DECERR) cycle.
  task automatic do_xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic push, input logic [31:0] er, input logic ee,
                         input int lat);
    int n;
    exp_t e;
    @(negedge pclk);
    bus.transfer  = 1'b1;
    bus.pwrite_in = wr;
    bus.addr      = a;
    bus.wdata     = wd;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge pclk);
      n++;
    end
    if (!bus.req_ready) check("req_ready_wait", 0, 1);
    if (push) begin
      e.rdata = er;
      e.err   = ee;
      e.cyc   = cyc + lat;
      sb_q.push_back(e);
    end
    @(posedge pclk);
    #1;
    bus.transfer = 1'b0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge pclk);
      n++;
    end
    check("rsp_arrived", sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.transfer  = 1'b0;
    bus.pwrite_in = 1'b0;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.prdata    = '0;
    bus.pready    = '0;
    bus.pslverr   = '0;

    // Reset values
    repeat (3) @(negedge pclk);
    check("rst_psel",      bus.psel,      4'b0000);
    check("rst_penable",   bus.penable,   0);
    check("rst_pwrite",    bus.pwrite,    0);
    check("rst_paddr",     bus.paddr,     0);
    check("rst_pwdata",    bus.pwdata,    0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_err",   bus.rsp_err,   0);
    presetn = 1'b1;
    @(negedge pclk);
    check("req_ready_after_rst", bus.req_ready, 1);

    // Zero-wait write to slave 2
    bus.pready = 4'b0100;
    do_xfer(1'b1, 32'h0000_2010, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, 3);
    @(negedge pclk);
    check("wr_setup_psel",    bus.psel,    4'b0100);
    check("wr_setup_penable", bus.penable, 0);
    check("wr_setup_paddr",   bus.paddr,   32'h0000_2010);
    check("wr_setup_pwdata",  bus.pwdata,  32'hDEAD_BEEF);
    check("wr_setup_pwrite",  bus.pwrite,  1);
    check("wr_setup_ready",   bus.req_ready, 0);
    @(negedge pclk);
    check("wr_access_psel",    bus.psel,    4'b0100);
    check("wr_access_penable", bus.penable, 1);
    @(negedge pclk);
    check("wr_done_psel",    bus.psel,      4'b0000);
    check("wr_done_penable", bus.penable,   0);
    check("wr_done_ready",   bus.req_ready, 1);
    wait_rsp();

    // Read from slave 1 with 3 wait states; other slaves' pready must be ignored
    bus.prdata = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'h0BAD_0BAD};
    bus.pready = 4'b1101;
    do_xfer(1'b0, 32'h0000_1004, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 6);
    @(negedge pclk);
    check("ws_setup_psel",    bus.psel,    4'b0010);
    check("ws_setup_penable", bus.penable, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      check("ws_access_psel",    bus.psel,      4'b0010);
      check("ws_access_penable", bus.penable,   1);
      check("ws_access_paddr",   bus.paddr,     32'h0000_1004);
      check("ws_access_pwrite",  bus.pwrite,    0);
      check("ws_access_noresp",  bus.rsp_valid, 0);
      if (i == 3) bus.pready[1] = 1'b1;
    end
    wait_rsp();

    // Read with slave error: rdata forced to zero
    bus.prdata  = {32'hCAFE_F00D, 32'h2222_2222, 32'h1111_1111, 32'hA5A5_0001};
    bus.pready  = 4'b1000;
    bus.pslverr = 4'b1000;
    do_xfer(1'b0, 32'h0000_3000, 32'h0, 1'b1, 32'h0, 1'b1, 3);
    wait_rsp();

    // Read from slave 0 while unselected slaves flag errors
    bus.pready  = 4'b0001;
    bus.pslverr = 4'b1110;
    do_xfer(1'b0, 32'h0000_0008, 32'h0, 1'b1, 32'hA5A5_0001, 1'b0, 3);
    wait_rsp();

    // Write at the top of the decoded range: write returns zero rdata
    bus.pready  = 4'b1000;
    bus.pslverr = 4'b0000;
    do_xfer(1'b1, 32'h0000_3FFC, 32'h0123_4567, 1'b1, 32'h0, 1'b0, 3);
    @(negedge pclk);
    check("top_setup_psel",  bus.psel,  4'b1000);
    check("top_setup_paddr", bus.paddr, 32'h0000_3FFC);
    wait_rsp();

    // Decode errors: no APB select, response two cycles after acceptance
    bus.pready = 4'b1111;
    do_xfer(1'b0, 32'h0001_0000, 32'h0, 1'b1, 32'h0, 1'b1, 2);
    @(negedge pclk);
    check("dec_psel",    bus.psel,    4'b0000);
    check("dec_penable", bus.penable, 0);
    wait_rsp();
    do_xfer(1'b1, 32'h0000_4000, 32'h5555_AAAA, 1'b1, 32'h0, 1'b1, 2);
    @(negedge pclk);
    check("dec2_psel", bus.psel, 4'b0000);
    wait_rsp();

    // Reset during ACCESS: select drops asynchronously, no response
    bus.pready = 4'b0000;
    do_xfer(1'b0, 32'h0000_1000, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    repeat (3) @(negedge pclk);
    check("pre_rst_penable", bus.penable, 1);
    #2;
    presetn = 1'b0;
    #1;
    check("midrst_psel",      bus.psel,      4'b0000);
    check("midrst_penable",   bus.penable,   0);
    check("midrst_req_ready", bus.req_ready, 0);
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    check("post_rst_ready", bus.req_ready, 1);
    check("post_rst_noresp", bus.rsp_valid, 0);

    // Slave never ready
`ifdef APB_TIMEOUT_EN
    do_xfer(1'b0, 32'h0000_2000, 32'h0, 1'b1, 32'h0, 1'b1, 18);
    wait_rsp();
`else
    do_xfer(1'b0, 32'h0000_2000, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    repeat (100) @(negedge pclk);
    check("hang_psel",    bus.psel,      4'b0100);
    check("hang_penable", bus.penable,   1);
    check("hang_noresp",  bus.rsp_valid, 0);
    check("hang_ready",   bus.req_ready, 0);
    presetn = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
`endif

    // Back in service after the stall
    bus.pready = 4'b0100;
    bus.prdata = {32'h0, 32'h7777_8888, 32'h0, 32'h0};
    do_xfer(1'b0, 32'h0000_2FF0, 32'h0, 1'b1, 32'h7777_8888, 1'b0, 3);
    wait_rsp();

    repeat (2) @(negedge pclk);
    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_multi_slave_master.md
Name: apb_multi_slave_master

Overview:
- Parametrised APB3 master with an integrated address decoder. Replaces the single-slave master in the APB subsystem.
- Accepts one request at a time on a simple transfer/ready interface and runs the APB SETUP/ACCESS sequence.
- Selects one of NUM_SLV slaves by address and honours per-slave PREADY wait states and PSLVERR.
- Returns a single-cycle response with read data and an error flag.

Parameters:
- ADDR_W, 32, width of paddr and addr.
- DATA_W, 32, width of pwdata, prdata and rdata.
- NUM_SLV, 4, number of APB slaves; must be a power of two, at least 2.
- SLV_ADDR_LSB, 12, LSB of the slave-index field; the field is addr[SLV_ADDR_LSB +: $clog2(NUM_SLV)].
- TIMEOUT_CYC, 16, number of ACCESS cycles without PREADY before abort. Used only with APB_TIMEOUT_EN.

Ports:
- pclk  in  1  clock.
- presetn  in  1  asynchronous active-low reset.
- transfer  in  1  request valid.
- pwrite_in  in  1  request direction: 1 = write.
- addr  in  ADDR_W  request address.
- wdata  in  DATA_W  request write data.
- req_ready  out  1  master can accept a request.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  DATA_W  read data.
- rsp_err  out  1  slave error, decode error or timeout.
- psel  out  NUM_SLV  one-hot slave select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  NUM_SLV*DATA_W  concatenated slave read data; slave i occupies [i*DATA_W +: DATA_W].
- pready  in  NUM_SLV  per-slave ready.
- pslverr  in  NUM_SLV  per-slave error.

Behaviour:
- Reset (presetn=0, asynchronous):
  - state=IDLE.
  - psel=0, penable=0, pwrite=0, paddr=0, pwdata=0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- req_ready is registered. It goes to 1 on the first pclk edge after reset release and is 1 only while in IDLE.
- Decode: addr bits above the slave-index field (bits ADDR_W-1 down to SLV_ADDR_LSB+$clog2(NUM_SLV)) must all be zero. Otherwise the request is a decode error.
- States IDLE, SETUP, ACCESS, DECERR. All outputs are registered.
- IDLE:
  - On transfer && req_ready: latch addr, wdata and pwrite_in into paddr, pwdata and pwrite; latch the slave index; drop req_ready.
  - If the address decodes, drive psel[idx]=1, penable=0 and go to SETUP. Otherwise go to DECERR with psel=0.
- SETUP: exactly one cycle, then ACCESS with penable=1. psel and the address/data outputs are held.
- ACCESS:
  - Wait while pready[idx]=0; all APB outputs are held stable.
  - On pready[idx]=1, at the next edge:
    - psel=0 and penable=0.
    - rsp_valid=1 for one cycle.
    - rsp_err=pslverr[idx].
    - rsp_rdata = prdata slice idx for a read with no error; 0 for a write or on error.
    - Return to IDLE with req_ready=1.
- DECERR: one cycle. Then rsp_valid=1, rsp_err=1, rsp_rdata=0, and return to IDLE. No APB cycle is issued.
- Latency:
  - Zero-wait-state transfer: transfer accepted at edge N, SETUP at N+1, ACCESS at N+2, rsp_valid at N+3, req_ready again at N+3.
  - Each wait state adds one cycle.
  - Minimum 3 cycles per transfer; there is no back-to-back pipelining.
- transfer while req_ready=0 is ignored. The requester must hold the request until it sees req_ready.
- pready and pslverr from non-selected slaves are ignored.
- pslverr is sampled only in ACCESS when pready is 1.
- Reset mid-transfer drops psel and penable immediately (asynchronous) and produces no response.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined: a counter clears on entry to ACCESS and increments each ACCESS cycle with pready[idx]=0. When it reaches TIMEOUT_CYC, the next edge aborts the transfer: psel=0, penable=0, rsp_valid=1, rsp_err=1, rsp_rdata=0, state=IDLE.
- If pready arrives in the same cycle the count reaches TIMEOUT_CYC, pready wins.
- Not defined: no counter; the master waits indefinitely and TIMEOUT_CYC is unused.

Decomposition:
- Package apb_pkg:
  - typedef enum apb_state_e {IDLE, SETUP, ACCESS, DECERR}.
  - localparam function for index width, $clog2(NUM_SLV).
- Sub-module apb_addr_decoder: combinational. Inputs addr; outputs one-hot sel vector, idx and dec_err. Parametrised by ADDR_W, NUM_SLV, SLV_ADDR_LSB.

Test Plan (NUM_SLV=4, SLV_ADDR_LSB=12):
- Write addr=0x0000_2010, wdata=0xDEAD_BEEF, pready[2] tied 1 -> psel=4'b0100 for 2 cycles, penable only in the second, paddr=0x2010, pwdata=0xDEADBEEF; rsp_valid 3 cycles after acceptance with rsp_err=0.
- Read addr=0x0000_1004, slave 1 returns 0x1234_5678 after 3 wait states -> ACCESS lasts 4 cycles with outputs stable; rsp_rdata=0x12345678; rsp_valid at acceptance+6.
- Read addr=0x0000_3000 with pslverr[3]=1 on the pready cycle -> rsp_err=1, rsp_rdata=0.
- addr=0x0001_0000 -> no psel asserted; rsp_valid=1, rsp_err=1 two cycles after acceptance.
- presetn pulled low during ACCESS -> psel and penable go 0 immediately, no rsp_valid; req_ready=1 one cycle after release.
- With APB_TIMEOUT_EN and TIMEOUT_CYC=16, pready held 0 -> abort after 16 ACCESS cycles with rsp_err=1. Without the macro, the same stimulus shows the master still in ACCESS after 100 cycles.
